// File: rtl/raster_capture.sv
// Raster tracker: turns the VDP pixel stream into framebuffer write strobes with x/y
// coordinates and truncated colour, and locks the active frame size after two matching frames.
module raster_capture #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int COLOR_BITS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ce_pix_in,
    input  logic                      hblank,
    input  logic                      vblank,
    input  logic [7:0]                r_in,
    input  logic [7:0]                g_in,
    input  logic [7:0]                b_in,
    output logic                      ce_pix,
    output logic [COLOR_BITS-1:0]     r,
    output logic [COLOR_BITS-1:0]     g,
    output logic [COLOR_BITS-1:0]     b,
    output logic [$clog2(WIDTH)-1:0]  x,
    output logic [$clog2(HEIGHT)-1:0] y,
    output logic [10:0]               width,
    output logic [9:0]                height,
    output logic                      locked,
    output logic                      frame_start
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic [10:0] WIDTH_L  = 11'(WIDTH);
    localparam logic [9:0]  HEIGHT_L = 10'(HEIGHT);

    typedef enum logic [1:0] {
        SEEK    = 2'd0,
        CAPTURE = 2'd1,
        VBL     = 2'd2
    } state_t;

    function automatic logic [10:0] sat_inc_x(input logic [10:0] v);
        return (v == 11'h7ff) ? v : v + 11'd1;
    endfunction

    function automatic logic [9:0] sat_inc_y(input logic [9:0] v);
        return (v == 10'h3ff) ? v : v + 10'd1;
    endfunction

    state_t      state;
    logic        hblank_q;
    logic        vblank_q;
    logic [10:0] xcnt;
    logic [9:0]  ycnt;
    logic [10:0] maxw;
    logic [10:0] cand_w;
    logic [9:0]  cand_h;

    logic        accept;
    logic        h_rise;
    logic        v_rise;
    logic        v_fall;
    logic        in_capture;
    logic        active;
    logic        line_end;
    logic [10:0] meas_w;
    logic [9:0]  meas_h;

    // A strobe right after an emitted pixel is dropped so ce_pix always has a low gap.
    assign accept     = ce_pix_in & ~ce_pix;
    assign h_rise     = accept & hblank & ~hblank_q;
    assign v_rise     = accept & vblank & ~vblank_q;
    assign v_fall     = accept & ~vblank & vblank_q;
    assign in_capture = (state == CAPTURE);
    assign active     = accept & ~hblank & ~vblank & in_capture;
    assign line_end   = in_capture & h_rise & (xcnt != 11'd0);

    // The measurement includes a line that ends on the same strobe as the frame.
    assign meas_w = (line_end && (xcnt > maxw)) ? xcnt : maxw;
    assign meas_h = line_end ? sat_inc_y(ycnt) : ycnt;

    logic unused_bits;
    assign unused_bits = ^{r_in[7-COLOR_BITS:0], g_in[7-COLOR_BITS:0], b_in[7-COLOR_BITS:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SEEK;
            hblank_q    <= 1'b0;
            vblank_q    <= 1'b0;
            xcnt        <= '0;
            ycnt        <= '0;
            maxw        <= '0;
            cand_w      <= '0;
            cand_h      <= '0;
            ce_pix      <= 1'b0;
            frame_start <= 1'b0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
            x           <= '0;
            y           <= '0;
            width       <= WIDTH_L;
            height      <= HEIGHT_L;
            locked      <= 1'b0;
        end else begin
            ce_pix      <= 1'b0;
            frame_start <= 1'b0;

            if (accept) begin
                hblank_q <= hblank;
                vblank_q <= vblank;
            end

            unique case (state)
                SEEK, VBL: begin
                    if (v_fall) begin
                        state       <= CAPTURE;
                        frame_start <= 1'b1;
                        xcnt        <= '0;
                        ycnt        <= '0;
                        maxw        <= '0;
                    end
                end

                CAPTURE: begin
                    if (active) begin
                        x      <= xcnt[XW-1:0];
                        y      <= ycnt[YW-1:0];
                        r      <= r_in[7 -: COLOR_BITS];
                        g      <= g_in[7 -: COLOR_BITS];
                        b      <= b_in[7 -: COLOR_BITS];
                        xcnt   <= sat_inc_x(xcnt);
                        ce_pix <= (xcnt < WIDTH_L) && (ycnt < HEIGHT_L);
                    end

                    if (line_end) begin
                        maxw <= meas_w;
                        ycnt <= sat_inc_y(ycnt);
                        xcnt <= '0;
                    end

                    // Frame end: a repeated measurement locks, a new one becomes the candidate.
                    if (v_rise) begin
                        state <= VBL;
                        maxw  <= '0;
                        if (meas_h != 10'd0) begin
                            if ((meas_w == cand_w) && (meas_h == cand_h)) begin
                                width  <= meas_w;
                                height <= meas_h;
                                locked <= 1'b1;
                            end else begin
                                cand_w <= meas_w;
                                cand_h <= meas_h;
                                locked <= 1'b0;
                            end
                        end
                    end
                end

                default: state <= SEEK;
            endcase
        end
    end

endmodule

// File: tb/tb_raster_capture.sv
// Directed-sequence bench for raster_capture: random pixel colours and blanking widths,
// expected pixels and lock results derived from frame geometry.
module tb_raster_capture;

    localparam int WIDTH  = 32;
    localparam int HEIGHT = 24;
    localparam int CB     = 4;
    localparam int XW     = $clog2(WIDTH);
    localparam int YW     = $clog2(HEIGHT);
    localparam int VBL_LINES = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          ce_pix_in;
    logic          hblank;
    logic          vblank;
    logic [7:0]    r_in, g_in, b_in;
    logic          ce_pix;
    logic [CB-1:0] r, g, b;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [10:0]   width;
    logic [9:0]    height;
    logic          locked;
    logic          frame_start;

    raster_capture #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .COLOR_BITS(CB)) dut (
        .clk(clk), .reset(reset), .ce_pix_in(ce_pix_in), .hblank(hblank), .vblank(vblank),
        .r_in(r_in), .g_in(g_in), .b_in(b_in), .ce_pix(ce_pix), .r(r), .g(g), .b(b),
        .x(x), .y(y), .width(width), .height(height), .locked(locked),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int tests;
    int fails;

    // Lock model: what width/height/locked should read after each frame end.
    int m_w, m_h, cand_w, cand_h;
    bit m_lock;

    task automatic model_reset();
        m_w = WIDTH; m_h = HEIGHT; m_lock = 1'b0; cand_w = 0; cand_h = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit c, input bit hb, input bit vb, input bit rs,
                         input logic [23:0] rgb, input bit ece, input int ex, input int ey,
                         input bit efs);
        reset = rs; ce_pix_in = c; hblank = hb; vblank = vb;
        r_in = rgb[23:16]; g_in = rgb[15:8]; b_in = rgb[7:0];
        @(posedge clk);
        #1;
        chk("ce_pix", 32'(ce_pix), 32'(ece));
        chk("frame_start", 32'(frame_start), 32'(efs));
        if (ece) begin
            chk("x", 32'(x), ex);
            chk("y", 32'(y), ey);
            chk("r", 32'(r), 32'(rgb[23 -: CB]));
            chk("g", 32'(g), 32'(rgb[15 -: CB]));
            chk("b", 32'(b), 32'(rgb[7 -: CB]));
        end
    endtask

    // One strobe followed by either an idle cycle or, when dbl is set, a back-to-back strobe.
    task automatic strobe(input bit hb, input bit vb, input logic [23:0] rgb, input bit ece,
                          input int ex, input int ey, input bit efs, input bit dbl);
        drive(1'b1, hb, vb, 1'b0, rgb, ece, ex, ey, efs);
        drive(dbl, hb, vb, 1'b0, 24'($urandom), 1'b0, 0, 0, 1'b0);
    endtask

    task automatic chk_reset();
        chk("rst_ce_pix", 32'(ce_pix), 0);
        chk("rst_frame_start", 32'(frame_start), 0);
        chk("rst_x", 32'(x), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_rgb", 32'({r, g, b}), 0);
        chk("rst_width", 32'(width), WIDTH);
        chk("rst_height", 32'(height), HEIGHT);
        chk("rst_locked", 32'(locked), 0);
    endtask

    task automatic frame_end(input bit cap, input int mw, input int mh);
        if (cap && mh != 0) begin
            if (mw == cand_w && mh == cand_h) begin
                m_w = mw; m_h = mh; m_lock = 1'b1;
            end else begin
                cand_w = mw; cand_h = mh; m_lock = 1'b0;
            end
        end
        chk("width", 32'(width), m_w);
        chk("height", 32'(height), m_h);
        chk("locked", 32'(locked), 32'(m_lock));
    endtask

    task automatic vbl_lines(input int n, input int w, input int hbl, input bit cap,
                             input int mw, input int mh);
        for (int l = 0; l < n; l++) begin
            for (int i = 0; i < hbl + w; i++) begin
                strobe(i < hbl, 1'b1, 24'($urandom), 1'b0, 0, 0, 1'b0, 1'b0);
                if (l == 0 && i == 0) frame_end(cap, mw, mh);
            end
        end
    endtask

    task automatic run_frame(input int w, input int h, input int dbl_line, input int rst_line,
                             input bit fixed_px);
        int hbl;
        bit cap;
        logic [23:0] rgb;
        hbl = $urandom_range(4, 10);
        cap = 1'b1;
        for (int l = 0; l < h; l++) begin
            for (int i = 0; i < hbl; i++)
                strobe(1'b1, 1'b0, 24'($urandom), 1'b0, 0, 0, cap && l == 0 && i == 0, 1'b0);
            for (int c = 0; c < w; c++) begin
                rgb = (fixed_px && l == 0 && c == 0) ? 24'hA53CF0 : 24'($urandom);
                strobe(1'b0, 1'b0, rgb, cap && c < WIDTH && l < HEIGHT, c, l, 1'b0,
                       l == dbl_line && c == 3);
                if (l == rst_line && c == w / 2) begin
                    drive(1'b0, 1'b0, 1'b0, 1'b1, 24'h0, 1'b0, 0, 0, 1'b0);
                    chk_reset();
                    model_reset();
                    cap = 1'b0;
                end
            end
        end
        vbl_lines(VBL_LINES, w, hbl, cap, w, h);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        model_reset();
        reset = 1'b1; ce_pix_in = 1'b0; hblank = 1'b0; vblank = 1'b0;
        r_in = 8'h0; g_in = 8'h0; b_in = 8'h0;

        drive(1'b0, 1'b0, 1'b0, 1'b1, 24'h0, 1'b0, 0, 0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 24'h0, 1'b0, 0, 0, 1'b0);
        chk_reset();

        // Mid-frame video before any vblank: nothing may be written.
        for (int l = 0; l < 2; l++)
            for (int i = 0; i < 10 + WIDTH; i++)
                strobe(i < 10, 1'b0, 24'($urandom), 1'b0, 0, 0, 1'b0, 1'b0);
        vbl_lines(VBL_LINES, WIDTH, 10, 1'b0, 0, 0);

        run_frame(32, 22, -1, -1, 1'b1);
        run_frame(32, 22, 1, -1, 1'b0);
        run_frame(32, 22, -1, -1, 1'b0);
        run_frame(26, 22, -1, -1, 1'b0);
        run_frame(26, 22, -1, -1, 1'b0);
        run_frame(34, 22, -1, -1, 1'b0);
        run_frame(34, 22, -1, -1, 1'b0);
        run_frame(20, 26, -1, -1, 1'b0);
        run_frame(20, 26, -1, -1, 1'b0);
        run_frame(32, 22, -1, 5, 1'b0);
        run_frame(32, 22, -1, -1, 1'b0);
        run_frame(32, 22, -1, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/raster_capture.md
# raster_capture

Front-end raster tracker between the VDP video output and the framebuffer write port. It takes the raw pixel stream (pixel strobe, blanking flags, 8-bit RGB) and derives per-pixel framebuffer coordinates and truncated colour. It also measures the active frame size, reporting width/height only after the size has been stable across two frames. Its outputs drive the framebuffer's ce_pix/r/g/b/x/y/width/height inputs directly.

## Interface
- WIDTH, 320: max stored frame width; x wraps/clips against it
- HEIGHT, 240: max stored frame height
- COLOR_BITS, 4: output bits per channel (MSBs of 8-bit input)
- clk  in  1  megadrive clock, sole clock
- reset  in  1  synchronous, active-high
- ce_pix_in  in  1  VDP pixel strobe
- hblank  in  1  horizontal blank, sampled only when ce_pix_in=1
- vblank  in  1  vertical blank, sampled only when ce_pix_in=1
- r_in, g_in, b_in  in  8 each  pixel colour
- ce_pix  out  1  one-cycle write strobe per stored pixel
- r, g, b  out  COLOR_BITS each  colour = input[7 -: COLOR_BITS]
- x  out  $clog2(WIDTH)  pixel column
- y  out  $clog2(HEIGHT)  pixel row
- width  out  11  locked active width
- height  out  10  locked active height
- locked  out  1  width/height valid and stable
- frame_start  out  1  one-cycle pulse at start of each captured frame

## Operation
- Edge detection: hblank_q/vblank_q hold the previous sampled values, updated only on ce_pix_in cycles. Rise/fall is detected by comparing them with the current sample.
- Strobe spacing: a ce_pix_in arriving in the cycle right after an output ce_pix pulse is ignored entirely, with no counting and no sampling. This guarantees the low gap that the framebuffer's edge detect needs.
- FSM states:
  - SEEK (reset state): outputs are suppressed. On the vblank falling edge go to CAPTURE.
  - CAPTURE: active pixels are emitted. On the vblank rising edge go to VBL.
  - VBL: on the vblank falling edge go to CAPTURE.
- frame_start pulses on every SEEK->CAPTURE or VBL->CAPTURE transition. xcnt and ycnt clear on that transition.
- Active pixel: ce_pix_in & ~hblank & ~vblank in CAPTURE.
  - x<=xcnt, y<=ycnt, rgb<=MSBs, xcnt saturating++ (11 bits, max 2047).
  - ce_pix<=1 only if xcnt<WIDTH and ycnt<HEIGHT. Out-of-range pixels are still counted but not written.
- Line end (hblank rising edge in CAPTURE) applies only if xcnt>0:
  - maxw<=max(maxw,xcnt)
  - ycnt saturating++ (10 bits, max 1023)
  - xcnt<=0
- Line end with xcnt=0 is a no-op.
- Frame end (vblank rising edge in CAPTURE):
  - If the line-end and frame-end edges occur on the same strobe, process the line end first, so the last line is counted.
  - Measurement is (mw,mh) = (maxw incl. pending line, ycnt incl. pending line).
  - If mh=0: no measurement; lock state and outputs are unchanged.
  - Else if (mw,mh)==cand: width<=mw, height<=mh, locked<=1.
  - Else: cand<=(mw,mh), locked<=0, width/height hold their old values.
  - maxw clears.
- Reset in the middle of a frame returns to SEEK. The remainder of that frame is discarded.

## Timing
- Reset values: ce_pix 0, r/g/b 0, x 0, y 0, width 320, height 240, locked 0, frame_start 0, FSM SEEK, cand 0.
- Pixel latency: ce_pix/x/y/rgb are registered 1 cycle after the accepted ce_pix_in. Data is held until the next accepted pixel.
- ce_pix and frame_start are exactly 1 cycle wide.
- width/height/locked update 1 cycle after the ce_pix_in that carries the vblank rising edge.
- The first lock requires 2 complete frames after the first vblank falling edge. Any size change costs 1 frame unlocked followed by a relock.

## Test plan
- Reset, then 3 frames of 320x224 (ce every 2nd cycle; hblank 100 px, vblank 20 lines) -> no ce_pix before the first vblank fall; frame 1 end: locked=0, width=320, height=240; frame 2 end: locked=1, width=320, height=224; last pixel x=319, y=223.
- Pixel 0xA5,0x3C,0xF0 at the first active position -> next cycle ce_pix=1, x=0, y=0, r=0xA, g=0x3, b=0xF; the following cycle ce_pix=0.
- Locked 320x224, then switch to 256x224 -> frame end: locked=0, width stays 320; next frame end: locked=1, width=256.
- Line of 330 active px with WIDTH=320 -> exactly 320 ce_pix pulses; measured width 330; after 2 frames width=330.
- ce_pix_in high on 2 consecutive cycles during active video -> only the first produces ce_pix; xcnt advances by 1.
- hblank and vblank rising edges on the same strobe after 224 lines -> height=224, not 223. Reset asserted mid-line -> all outputs return to reset values next cycle, and there is no ce_pix until the next vblank fall.
